// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Also provides min_digits(), used to reject digit counts too small for the input width.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] ADJ_THRESH = 4'd4;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    // Smallest number of decimal digits that can hold 2**n_bits - 1.
    function automatic int min_digits(input int n_bits);
        longint unsigned max_val;
        longint unsigned pow10;
        int              digits;
        max_val = (64'd1 << n_bits) - 64'd1;
        pow10   = 64'd10;
        digits  = 1;
        for (int i = 0; i < 20; i++) begin
            if (pow10 <= max_val) begin
                pow10  = pow10 * 64'd10;
                digits = digits + 1;
            end
        end
        return digits;
    endfunction

endpackage

// File: rtl/bin2bcd_dabble_step.sv
// One combinational add-3 pass of double dabble: every digit above 4 gets +3.
// All digits are adjusted in parallel, ahead of the one-place left shift.
module bin2bcd_dabble_step
    import bin2bcd_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic [BCD_W*N_DIGITS-1:0] bcd_in,
    output logic [BCD_W*N_DIGITS-1:0] bcd_out
);

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        logic [BCD_W-1:0] digit;
        assign digit = bcd_in[BCD_W*i +: BCD_W];
        assign bcd_out[BCD_W*i +: BCD_W] = (digit > ADJ_THRESH) ? (digit + ADJ_ADD) : digit;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative N_BITS binary to N_DIGITS packed BCD converter with start/ready/done handshake.
// Optional leading-zero blanking output blank_o is built when BIN2BCD_LZB_EN is defined.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int N_BITS    = 10,
    parameter int N_DIGITS  = 4,
    parameter int SIGNED_IN = 0
) (
    input  logic                      bin2bcd_clk,
    input  logic                      reset_,
    input  logic                      start_i,
    input  logic [N_BITS-1:0]         vmm_out,
    output logic                      ready_o,
    output logic                      done_o,
    output logic [BCD_W*N_DIGITS-1:0] bcd_o,
    output logic                      neg_o
`ifdef BIN2BCD_LZB_EN
    ,
    output logic [N_DIGITS-1:0]       blank_o
`endif
);

    localparam int DIG_W = BCD_W * N_DIGITS;
    localparam int CNT_W = $clog2(N_BITS + 1);

    if ((N_BITS < 2) || (N_BITS > 32)) begin : g_bad_width
        $error("bin2bcd_seq: N_BITS must lie in 2..32");
    end
    if (N_DIGITS < min_digits(N_BITS)) begin : g_bad_digits
        $error("bin2bcd_seq: N_DIGITS too small for N_BITS");
    end

    state_t             state;
    state_t             state_next;
    logic [DIG_W-1:0]   acc_bcd;
    logic [DIG_W-1:0]   adj_bcd;
    logic [DIG_W-1:0]   shift_bcd;
    logic [N_BITS-1:0]  mag_reg;
    logic [N_BITS-1:0]  shift_mag;
    logic [N_BITS-1:0]  mag_in;
    logic               is_neg;
    logic               neg_reg;
    logic [CNT_W-1:0]   count;
    logic               last_bit;

    bin2bcd_dabble_step #(
        .N_DIGITS (N_DIGITS)
    ) u_step (
        .bcd_in  (acc_bcd),
        .bcd_out (adj_bcd)
    );

    // The most negative input negates onto itself, which read unsigned is the right magnitude.
    always_comb begin
        is_neg = (SIGNED_IN != 0) && vmm_out[N_BITS-1];
        mag_in = is_neg ? ((~vmm_out) + N_BITS'(1)) : vmm_out;
        {shift_bcd, shift_mag} = {adj_bcd, mag_reg} << 1;
        last_bit = (count == CNT_W'(1));
    end

    always_ff @(posedge bin2bcd_clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef BIN2BCD_LZB_EN
    logic [N_DIGITS-1:0] blank_next;
    logic                zero_above;

    // Walk down from the top digit; digit 0 is never blanked so zero still shows.
    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (shift_bcd[BCD_W*i +: BCD_W] == '0);
            blank_next[i] = zero_above;
        end
    end

    always_ff @(posedge bin2bcd_clk or negedge reset_) begin
        if (!reset_) begin
            blank_o <= '0;
        end else if ((state == SHIFT) && last_bit) begin
            blank_o <= blank_next;
        end
    end
`endif

    // Visible results only change on the edge entering DONE; the accumulator stays private.
    always_ff @(posedge bin2bcd_clk or negedge reset_) begin
        if (!reset_) begin
            acc_bcd <= '0;
            mag_reg <= '0;
            neg_reg <= 1'b0;
            count   <= '0;
            bcd_o   <= '0;
            neg_o   <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mag_reg <= mag_in;
                        neg_reg <= is_neg;
                        acc_bcd <= '0;
                        count   <= CNT_W'(N_BITS);
                    end
                end
                SHIFT: begin
                    acc_bcd <= shift_bcd;
                    mag_reg <= shift_mag;
                    count   <= count - CNT_W'(1);
                    if (last_bit) begin
                        bcd_o  <= shift_bcd;
                        neg_o  <= neg_reg;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Drives an unsigned and a signed bin2bcd_seq side by side with the same operands and
// compares both against decimal arithmetic done directly on the operand value.
module tb_bin2bcd_seq;

    localparam int N_BITS   = 10;
    localparam int N_DIGITS = 4;
    localparam int DIG_W    = 4 * N_DIGITS;
    localparam int LATENCY  = N_BITS + 1;

    logic              bin2bcd_clk = 1'b0;
    logic              reset_;
    logic              start_i;
    logic [N_BITS-1:0] vmm_out;

    logic              u_ready, u_done, u_neg;
    logic [DIG_W-1:0]  u_bcd;
    logic              s_ready, s_done, s_neg;
    logic [DIG_W-1:0]  s_bcd;
`ifdef BIN2BCD_LZB_EN
    logic [N_DIGITS-1:0] u_blank, s_blank;
`endif

    int checks = 0;
    int errors = 0;

    logic [DIG_W-1:0] prev_u_bcd;
    logic [DIG_W-1:0] prev_s_bcd;

    always #5 bin2bcd_clk = ~bin2bcd_clk;

    bin2bcd_seq #(.N_BITS(N_BITS), .N_DIGITS(N_DIGITS), .SIGNED_IN(0)) u_dut (
        .bin2bcd_clk (bin2bcd_clk),
        .reset_      (reset_),
        .start_i     (start_i),
        .vmm_out     (vmm_out),
        .ready_o     (u_ready),
        .done_o      (u_done),
        .bcd_o       (u_bcd),
        .neg_o       (u_neg)
`ifdef BIN2BCD_LZB_EN
        ,
        .blank_o     (u_blank)
`endif
    );

    bin2bcd_seq #(.N_BITS(N_BITS), .N_DIGITS(N_DIGITS), .SIGNED_IN(1)) s_dut (
        .bin2bcd_clk (bin2bcd_clk),
        .reset_      (reset_),
        .start_i     (start_i),
        .vmm_out     (vmm_out),
        .ready_o     (s_ready),
        .done_o      (s_done),
        .bcd_o       (s_bcd),
        .neg_o       (s_neg)
`ifdef BIN2BCD_LZB_EN
        ,
        .blank_o     (s_blank)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [DIG_W-1:0] ref_bcd(input int unsigned value);
        logic [DIG_W-1:0] r;
        int unsigned      v;
        r = '0;
        v = value;
        for (int i = 0; i < N_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int unsigned ref_signed_mag(input logic [N_BITS-1:0] x);
        logic signed [N_BITS-1:0] sx;
        int                       s;
        sx = x;
        s  = sx;
        return (s < 0) ? int'(-s) : s;
    endfunction

    function automatic logic ref_signed_neg(input logic [N_BITS-1:0] x);
        logic signed [N_BITS-1:0] sx;
        sx = x;
        return sx < 0;
    endfunction

    function automatic logic [N_DIGITS-1:0] ref_blank(input int unsigned value);
        logic [N_DIGITS-1:0] r;
        int unsigned         p;
        r = '0;
        p = 1;
        for (int i = 1; i < N_DIGITS; i++) begin
            p    = p * 10;
            r[i] = (value < p);
        end
        return r;
    endfunction

    task automatic checkResult(input string tag, input logic [N_BITS-1:0] value);
        checkOutput({tag, "_u_bcd"}, 32'(u_bcd), 32'(ref_bcd(value)));
        checkOutput({tag, "_u_neg"}, 32'(u_neg), 32'd0);
        checkOutput({tag, "_s_bcd"}, 32'(s_bcd), 32'(ref_bcd(ref_signed_mag(value))));
        checkOutput({tag, "_s_neg"}, 32'(s_neg), 32'(ref_signed_neg(value)));
`ifdef BIN2BCD_LZB_EN
        checkOutput({tag, "_u_blank"}, 32'(u_blank), 32'(ref_blank(value)));
        checkOutput({tag, "_s_blank"}, 32'(s_blank), 32'(ref_blank(ref_signed_mag(value))));
`endif
        prev_u_bcd = ref_bcd(value);
        prev_s_bcd = ref_bcd(ref_signed_mag(value));
    endtask

    // One conversion; poke_cycle > 0 pulses start_i with another operand mid-SHIFT.
    task automatic applyStimulus(input logic [N_BITS-1:0] value, input int poke_cycle);
        int   latency   = -1;
        int   done_cnt  = 0;
        logic ready_bad = 1'b0;
        logic hold_bad  = 1'b0;
        logic sync_bad  = 1'b0;
        @(negedge bin2bcd_clk);
        start_i = 1'b1;
        vmm_out = value;
        @(posedge bin2bcd_clk);
        for (int cyc = 1; cyc <= LATENCY + 3; cyc++) begin
            @(negedge bin2bcd_clk);
            if (cyc == 1) begin
                start_i = 1'b0;
                vmm_out = N_BITS'($urandom);
            end
            if ((poke_cycle > 0) && (cyc == poke_cycle)) begin
                start_i = 1'b1;
                vmm_out = value ^ 10'h2AA;
            end
            if ((poke_cycle > 0) && (cyc == poke_cycle + 1)) begin
                start_i = 1'b0;
            end
            if (s_done !== u_done) sync_bad = 1'b1;
            if (cyc <= LATENCY && u_ready !== 1'b0) ready_bad = 1'b1;
            if (cyc == LATENCY + 1 && u_ready !== 1'b1) ready_bad = 1'b1;
            if (u_done === 1'b1) begin
                done_cnt++;
                if (latency < 0) begin
                    latency = cyc;
                    checkResult($sformatf("conv%0d", value), value);
                end
            end else if (latency < 0) begin
                if (u_bcd !== prev_u_bcd || s_bcd !== prev_s_bcd) hold_bad = 1'b1;
            end
        end
        checkOutput("latency", 32'(latency), 32'(LATENCY));
        checkOutput("done_pulses", 32'(done_cnt), 32'd1);
        checkOutput("ready_profile", 32'(ready_bad), 32'd0);
        checkOutput("bcd_hold_before_done", 32'(hold_bad), 32'd0);
        checkOutput("signed_done_sync", 32'(sync_bad), 32'd0);
    endtask

    // start_i held high across two conversions; the second picks up the operand at the next IDLE.
    task automatic backToBack();
        int first  = -1;
        int second = -1;
        @(negedge bin2bcd_clk);
        start_i = 1'b1;
        vmm_out = '0;
        @(posedge bin2bcd_clk);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge bin2bcd_clk);
            if (cyc == 1) vmm_out = 10'd999;
            if (u_done === 1'b1) begin
                if (first < 0) begin
                    first = cyc;
                    checkResult("b2b_zero", 10'd0);
                end else begin
                    second = cyc;
                    checkResult("b2b_999", 10'd999);
                    start_i = 1'b0;
                    break;
                end
            end
        end
        start_i = 1'b0;
        checkOutput("b2b_first_latency", 32'(first), 32'(LATENCY));
        checkOutput("b2b_gap", 32'(second - first), 32'(N_BITS + 2));
        @(negedge bin2bcd_clk);
    endtask

    task automatic resetMidShift();
        @(negedge bin2bcd_clk);
        start_i = 1'b1;
        vmm_out = 10'd500;
        @(posedge bin2bcd_clk);
        @(negedge bin2bcd_clk);
        start_i = 1'b0;
        repeat (4) @(negedge bin2bcd_clk);
        reset_ = 1'b0;
        #1;
        checkOutput("rst_u_ready", 32'(u_ready), 32'd1);
        checkOutput("rst_u_done", 32'(u_done), 32'd0);
        checkOutput("rst_u_bcd", 32'(u_bcd), 32'd0);
        checkOutput("rst_s_bcd", 32'(s_bcd), 32'd0);
        checkOutput("rst_s_neg", 32'(s_neg), 32'd0);
`ifdef BIN2BCD_LZB_EN
        checkOutput("rst_u_blank", 32'(u_blank), 32'd0);
`endif
        @(negedge bin2bcd_clk);
        reset_     = 1'b1;
        prev_u_bcd = '0;
        prev_s_bcd = '0;
    endtask

    initial begin
        reset_     = 1'b0;
        start_i    = 1'b0;
        vmm_out    = '0;
        prev_u_bcd = '0;
        prev_s_bcd = '0;
        repeat (2) @(negedge bin2bcd_clk);
        checkOutput("reset_u_ready", 32'(u_ready), 32'd1);
        checkOutput("reset_u_done", 32'(u_done), 32'd0);
        checkOutput("reset_u_bcd", 32'(u_bcd), 32'd0);
        checkOutput("reset_s_neg", 32'(s_neg), 32'd0);
        checkOutput("reset_s_ready", 32'(s_ready), 32'd1);
        reset_ = 1'b1;

        applyStimulus(10'd1023, 0);
        backToBack();
        applyStimulus(10'h200, 0);
        applyStimulus(10'h3FF, 0);
        applyStimulus(10'd300, 4);
        resetMidShift();
        applyStimulus(10'd37, 0);
        applyStimulus(10'd7, 0);
        applyStimulus(10'd0, 0);
        applyStimulus(10'd1000, 0);
        applyStimulus(10'd511, 0);
        for (int n = 0; n < 16; n++) begin
            applyStimulus(N_BITS'($urandom_range(0, 1023)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 8)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised successor to the 10-bit iterative binary-to-BCD converter. Converts an N_BITS binary word to N_DIGITS packed BCD digits using shift-add-3 (double dabble). Optional two's-complement input gives sign plus magnitude. Sits between the VMM accumulator output and the display/UART formatting logic, with a start/ready/done handshake.

Parameters:
N_BITS, 10, input word width; legal range 2..32.
N_DIGITS, 4, BCD digits produced; elaboration error if 10**N_DIGITS <= 2**N_BITS - 1.
SIGNED_IN, 0, 1 = input is two's complement; magnitude is converted and neg_o is driven.

Ports:
bin2bcd_clk  in  1  clock; all state updates on the rising edge.
reset_  in  1  asynchronous, active-low reset.
start_i  in  1  request a conversion; accepted only while ready_o=1.
vmm_out  in  N_BITS  binary operand, sampled on the accepting edge.
ready_o  out  1  high in IDLE only.
done_o  out  1  one-cycle pulse when bcd_o and neg_o are valid.
bcd_o  out  4*N_DIGITS  packed BCD; digit i occupies bits [4i+3:4i]; digit 0 is least significant.
neg_o  out  1  sign of the captured operand; tied 0 when SIGNED_IN=0.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; bcd_o=0; neg_o=0; done_o=0; ready_o=1; shift register and counter cleared. The iteration counter is reset, unlike the prior generation.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start_i=1 at edge t0:
  - capture magnitude: vmm_out, or |vmm_out| when SIGNED_IN=1 and the MSB is set; -2**(N_BITS-1) maps to unsigned 2**(N_BITS-1);
  - capture neg_o;
  - clear BCD accumulator;
  - count = N_BITS;
  - go to SHIFT.
- IDLE, start_i=0: hold all outputs.
- SHIFT, one bit per cycle, per edge:
  - each digit >4 gets +3, all digits in parallel, combinationally;
  - the {BCD, magnitude} vector shifts left one place; the magnitude MSB enters digit 0 bit 0;
  - count decrements;
  - on the edge where count goes 1->0, go to DONE.
- DONE:
  - done_o=1 for exactly one cycle;
  - bcd_o is updated from the accumulator on the edge entering DONE;
  - next edge returns to IDLE.
- Latency: done_o is high in the cycle after edge t0+N_BITS (N_BITS+1 cycles after acceptance). Throughput is one conversion per N_BITS+2 cycles.
- bcd_o and neg_o hold their last result until the next DONE; intermediate shift values are never visible on bcd_o.
- start_i in SHIFT or DONE is ignored, not queued. A start_i held high through DONE is accepted in the following IDLE cycle.
- vmm_out changing after t0 has no effect.
- Adjust arithmetic is 4-bit per digit and cannot exceed 12 before the shift. The top digit is never adjusted past its range because of the N_DIGITS legality check.
- Counter width: $clog2(N_BITS+1).

Optional Feature:
BIN2BCD_LZB_EN
- Defined: adds output blank_o [N_DIGITS-1:0], registered with bcd_o and reset to 0.
  - bit i=1 iff digit i and every higher digit are zero;
  - bit 0 is always 0, so a value of 0 shows a single "0".
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- bin2bcd_pkg:
  - state enum (IDLE/SHIFT/DONE);
  - BCD_W=4 and ADJ_THRESH=4 constants;
  - function min_digits(n_bits) for the parameter check.
- One sub-module, bin2bcd_dabble_step: combinational, parametrised by N_DIGITS; maps the accumulator to the add-3-adjusted accumulator. Instanced once, feeding the shift.

Test Plan:
- N_BITS=10, vmm_out=1023, start at t0 -> done_o pulse 11 cycles later; bcd_o=0x1023; neg_o=0; ready_o low through DONE.
- vmm_out=0, then vmm_out=999 back-to-back with start_i held high -> two done pulses 12 cycles apart; bcd_o=0x0000, then 0x0999.
- SIGNED_IN=1: vmm_out=10'h200 (-512) -> bcd_o=0x0512, neg_o=1; vmm_out=10'h3FF (-1) -> bcd_o=0x0001, neg_o=1.
- start_i pulsed mid-SHIFT with a different vmm_out -> ignored; result matches the first operand; exactly one done pulse.
- reset_ low at cycle 5 of SHIFT, released, then start with 37 -> all outputs 0 during reset; next result 0x0037 with normal latency.
- BIN2BCD_LZB_EN defined: 7 -> blank_o=4'b1110; 0 -> 4'b1110; 1000 -> 4'b0000.
